// File: rtl/skid_pipe_reg_pkg.sv
// skid_pipe_reg_pkg
//   Shared constants and types for the skid_pipe_reg pipeline stage.
//   NOP_INSN     : default bubble payload (the nop instruction encoding).
//   skid_state_e : occupancy of the two-entry stage, encoded as {skid_v, main_v}.
package skid_pipe_reg_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter; sticks at all-ones and never wraps.
//   clk_i : clock          rst   : async active-high reset (clears count)
//   inc_i : count enable   clr_i : synchronous clear (wins over inc_i)
//   cnt_o : current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst)
      cnt_o <= '0;
    else if (clr_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != {CNT_W{1'b1}}))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg
//   Pipeline stage register with optional two-entry skid buffer, flush and a
//   saturating back-pressure counter.
//   clk_i        : clock                    rst          : async active-high reset
//   in_valid_i   : upstream entry valid     in_data_i    : upstream payload
//   in_ready_o   : stage accepts this cycle flush_i      : drop every held entry
//   out_valid_o  : head entry valid         out_data_o   : head payload (NOP_VALUE when idle)
//   out_ready_i  : downstream allow-in      stall_cnt_o  : cycles of valid & ~ready
//   SKID_EN=1 : two entries, in_ready_o comes from a flop (no ready->ready path).
//   SKID_EN=0 : one entry, in_ready_o = out_ready_i | ~main_v.
module skid_pipe_reg
  import skid_pipe_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_INSN),
  parameter int unsigned       SKID_EN   = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              accept, fire, stall_inc;
  skid_state_e       state;

  assign state     = skid_state_e'({skid_v, main_v});
  assign accept    = in_valid_i & in_ready_o & ~flush_i;
  assign fire      = main_v & out_ready_i;
  assign stall_inc = main_v & ~out_ready_i & ~flush_i;

  assign out_valid_o = main_v;
  assign out_data_o  = main_q;

  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready_o = ~skid_v;
    end else begin : g_single
      assign in_ready_o = out_ready_i | ~main_v;
    end
  endgenerate

  // main_q is reloaded with NOP_VALUE when the last entry drains so that
  // out_data_o can stay a bare flop output while still reading as a bubble.
  // skid_q is left stale after a skid->main move; skid_v masks it.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (SKID_EN != 0) begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_v <= 1'b1;
            main_q <= in_data_i;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            main_q <= in_data_i;
          end else if (accept) begin
            skid_v <= 1'b1;
            skid_q <= in_data_i;
          end else if (fire) begin
            main_v <= 1'b0;
            main_q <= NOP_VALUE;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so only the skid->main move can happen
          if (fire) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
          end
        end
        default: ;
      endcase
    end else begin
      if (accept) begin
        main_v <= 1'b1;
        main_q <= in_data_i;
      end else if (fire) begin
        main_v <= 1'b0;
        main_q <= NOP_VALUE;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst   (rst),
    .inc_i (stall_inc),
    .clr_i (1'b0),
    .cnt_o (stall_cnt_o)
  );

endmodule
